// File: rtl/tetris_input_pkg.sv
// Shared keycodes, game-state encodings and enums for the keyboard front end.
package tetris_input_pkg;

   localparam logic [7:0] KC_A     = 8'h04;
   localparam logic [7:0] KC_D     = 8'h07;
   localparam logic [7:0] KC_S     = 8'h16;
   localparam logic [7:0] KC_W     = 8'h1A;
   localparam logic [7:0] KC_RIGHT = 8'h4F;
   localparam logic [7:0] KC_LEFT  = 8'h50;
   localparam logic [7:0] KC_DOWN  = 8'h51;
   localparam logic [7:0] KC_UP    = 8'h52;
   localparam logic [7:0] KC_SPACE = 8'h2C;

   localparam logic [2:0] GS_HALTED = 3'b000;
   localparam logic [2:0] GS_START  = 3'b001;
   localparam logic [2:0] GS_DROP   = 3'b010;
   localparam logic [2:0] GS_CLEAR  = 3'b011;

   typedef enum logic [1:0] {ACT_LEFT = 2'd0, ACT_RIGHT, ACT_DOWN, ACT_ROTATE} actIdx_t;
   typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rptState_t;

   function automatic int maxOf3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   // A key counts as held when either HID slot carries it.
   function automatic logic keyMatch(input logic [7:0] k0, input logic [7:0] k1,
                                     input logic [7:0] kc);
      return (k0 == kc) || (k1 == kc);
   endfunction

endpackage

// File: rtl/key_repeat_unit.sv
// One action: pulse on press, then optional delayed auto-shift and periodic repeat on frame ticks.
module key_repeat_unit
   import tetris_input_pkg::*;
#(
   parameter int FIRST_DELAY = 16,
   parameter int PERIOD      = 4,
   parameter bit REPEAT_EN   = 1'b1
) (
   input  logic Clk,
   input  logic Reset,
   input  logic enable,
   input  logic held,
   input  logic frame_tick,
   output logic pulse
);

   localparam int CNT_W = $clog2(maxOf3(FIRST_DELAY, PERIOD, 1)) + 1;
   localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'((FIRST_DELAY > 0) ? FIRST_DELAY - 1 : 0);
   localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'((PERIOD > 0) ? PERIOD - 1 : 0);

   rptState_t        stateReg, stateNext;
   logic [CNT_W-1:0] cntReg, cntNext;
   logic             prevReg;
   logic             pulseReg, pulseNext;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         stateReg <= IDLE;
         cntReg   <= '0;
         prevReg  <= 1'b0;
         pulseReg <= 1'b0;
      end else begin
         stateReg <= stateNext;
         cntReg   <= cntNext;
         prevReg  <= held;
         pulseReg <= pulseNext;
      end
   end

   // Release and gating take priority; a press edge swallows a coincident tick.
   always_comb begin
      stateNext = stateReg;
      cntNext   = cntReg;
      pulseNext = 1'b0;
      if (!enable || !held) begin
         stateNext = IDLE;
         cntNext   = '0;
      end else if (!prevReg) begin
         pulseNext = 1'b1;
         cntNext   = '0;
         if (REPEAT_EN == 1'b0)
            stateNext = IDLE;
         else if (FIRST_DELAY == 0)
            stateNext = REPEAT;
         else
            stateNext = DELAY;
      end else if (frame_tick) begin
         case (stateReg)
            DELAY: begin
               if (cntReg == DELAY_LAST) begin
                  pulseNext = 1'b1;
                  stateNext = REPEAT;
                  cntNext   = '0;
               end else begin
                  cntNext = cntReg + 1'b1;
               end
            end
            REPEAT: begin
               if (cntReg == PERIOD_LAST) begin
                  pulseNext = 1'b1;
                  cntNext   = '0;
               end else begin
                  cntNext = cntReg + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign pulse = pulseReg;

endmodule

// File: rtl/tetris_key_decoder.sv
// HID keycode slots to registered per-player action pulses and a start pulse, gated by game state.
module tetris_key_decoder
   import tetris_input_pkg::*;
#(
   parameter int DAS_DELAY   = 16,
   parameter int ARR_PERIOD  = 4,
   parameter int DOWN_PERIOD = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_tick,
   input  logic [7:0] keycode,
   input  logic [7:0] keycode2,
   input  logic [2:0] game_state,
   output logic       start_pulse,
   output logic [3:0] p1_act,
   output logic [3:0] p2_act
);

   logic [7:0] heldNext, heldReg;
   logic       spaceHeldReg, spacePrevReg, startReg;
   logic [1:0] warmReg;
   logic [7:0] actPulse;
   logic       dropEnable, startEnable;
   logic       p1L, p1R, p2L, p2R;

   always_comb begin
      p1L = keyMatch(keycode, keycode2, KC_A);
      p1R = keyMatch(keycode, keycode2, KC_D);
      p2L = keyMatch(keycode, keycode2, KC_LEFT);
      p2R = keyMatch(keycode, keycode2, KC_RIGHT);
      heldNext = '0;
      heldNext[ACT_LEFT]       = p1L && !p1R;
      heldNext[ACT_RIGHT]      = p1R && !p1L;
      heldNext[ACT_DOWN]       = keyMatch(keycode, keycode2, KC_S);
      heldNext[ACT_ROTATE]     = keyMatch(keycode, keycode2, KC_W);
      heldNext[4 + ACT_LEFT]   = p2L && !p2R;
      heldNext[4 + ACT_RIGHT]  = p2R && !p2L;
      heldNext[4 + ACT_DOWN]   = keyMatch(keycode, keycode2, KC_DOWN);
      heldNext[4 + ACT_ROTATE] = keyMatch(keycode, keycode2, KC_UP);
   end

   // warmReg keeps pulses off until prev has been primed from held, so keys held through reset stay silent.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         heldReg      <= '0;
         spaceHeldReg <= 1'b0;
         spacePrevReg <= 1'b0;
         startReg     <= 1'b0;
         warmReg      <= 2'b00;
      end else begin
         heldReg      <= heldNext;
         spaceHeldReg <= keyMatch(keycode, keycode2, KC_SPACE);
         spacePrevReg <= spaceHeldReg;
         startReg     <= startEnable && spaceHeldReg && !spacePrevReg;
         warmReg      <= {warmReg[0], 1'b1};
      end
   end

   assign dropEnable  = (game_state == GS_DROP)  && warmReg[1];
   assign startEnable = (game_state == GS_START) && warmReg[1];

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : gUnit
         localparam int ACT    = gi % 4;
         localparam bit IS_DN  = (ACT == int'(ACT_DOWN));
         localparam bit IS_ROT = (ACT == int'(ACT_ROTATE));
         key_repeat_unit #(
            .FIRST_DELAY(IS_DN ? 0 : DAS_DELAY),
            .PERIOD     (IS_DN ? DOWN_PERIOD : (IS_ROT ? 1 : ARR_PERIOD)),
            .REPEAT_EN  (!IS_ROT)
         ) uUnit (
            .Clk       (Clk),
            .Reset     (Reset),
            .enable    (dropEnable),
            .held      (heldReg[gi]),
            .frame_tick(frame_tick),
            .pulse     (actPulse[gi])
         );
      end
   endgenerate

   assign start_pulse = startReg;
   assign p1_act      = actPulse[3:0];
   assign p2_act      = actPulse[7:4];

endmodule

// File: tb/tb_tetris_key_decoder.sv
// Scoreboard bench: expected output vectors are queued against the edge they must appear on.
module tb_tetris_key_decoder;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       frame_tick;
   logic [7:0] keycode, keycode2;
   logic [2:0] game_state;
   logic       start_pulse;
   logic [3:0] p1_act, p2_act;

   tetris_key_decoder dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_tick (frame_tick),
      .keycode    (keycode),
      .keycode2   (keycode2),
      .game_state (game_state),
      .start_pulse(start_pulse),
      .p1_act     (p1_act),
      .p2_act     (p2_act)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      int         e;
      logic [8:0] v;
   } exp_t;

   exp_t       expQ[$];
   int         edgeN = 0;
   int         nCompared = 0;
   int         nMismatched = 0;
   string      curTag = "reset";
   logic       rstV = 1'b1;
   logic [7:0] kA = 8'h00, kB = 8'h00;
   logic [2:0] gsV = 3'b010;

   localparam logic [8:0] START = 9'h100;
   localparam logic [8:0] P1L = 9'h010, P1R = 9'h020, P1ROT = 9'h080;
   localparam logic [8:0] P2L = 9'h001, P2DN = 9'h004;

   task automatic checkEq(input string tag, input logic [8:0] got, input logic [8:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("FAIL %s @edge %0d: got %h expected %h", tag, edgeN, got, exp);
      end else if (exp != 9'h0) begin
         $display("ok   %s @edge %0d: pulse %h", tag, edgeN, got);
      end
   endtask

   task automatic expectAt(input int e, input logic [8:0] v);
      expQ.push_back('{e: e, v: v});
   endtask

   // Drive inputs for the next edge, then check the outputs that edge registered.
   task automatic step(input logic tk);
      logic [8:0] expV;
      Reset = rstV; keycode = kA; keycode2 = kB; game_state = gsV; frame_tick = tk;
      @(posedge Clk);
      edgeN++;
      #1;
      expV = 9'h0;
      if (expQ.size() > 0 && expQ[0].e == edgeN) expV = expQ.pop_front().v;
      checkEq(curTag, {start_pulse, p1_act, p2_act}, expV);
   endtask

   task automatic idle(input int n, input logic tk);
      for (int i = 0; i < n; i++) step(tk);
   endtask

   initial begin
      // Key held through reset must not fire after reset drops.
      rstV = 1'b1; kA = 8'h04; gsV = 3'b010;
      idle(3, 1'b0);
      rstV = 1'b0;
      idle(5, 1'b0);
      kA = 8'h00; idle(2, 1'b0);
      curTag = "repress";
      expectAt(edgeN + 2, P1L); kA = 8'h04; idle(3, 1'b0);
      kA = 8'h00; idle(2, 1'b0);

      curTag = "start";
      gsV = 3'b001; kB = 8'h2C;
      expectAt(edgeN + 2, START); idle(5, 1'b0);
      kB = 8'h00; idle(3, 1'b0);
      curTag = "startInDrop";
      gsV = 3'b010; kB = 8'h2C; idle(5, 1'b0);
      kB = 8'h00; idle(3, 1'b0);

      curTag = "das";
      expectAt(edgeN + 2, P2L); kA = 8'h50;
      step(1'b0);
      for (int t = 1; t <= 40; t++) begin
         step(1'b0);
         if (t >= 16 && (t - 16) % 4 == 0) expectAt(edgeN + 1, P2L);
         step(1'b1);
      end
      curTag = "dasRelease";
      kA = 8'h00; idle(2, 1'b0);
      for (int t = 0; t < 10; t++) begin step(1'b0); step(1'b1); end

      curTag = "conflict";
      kA = 8'h04; kB = 8'h07; idle(4, 1'b0);
      expectAt(edgeN + 2, P1L); kB = 8'h00; idle(3, 1'b0);
      kA = 8'h00; idle(2, 1'b0);

      curTag = "rotate";
      expectAt(edgeN + 2, P1ROT); kA = 8'h1A;
      step(1'b0);
      for (int t = 0; t < 50; t++) begin step(1'b0); step(1'b1); end
      kA = 8'h00; idle(3, 1'b0);
      curTag = "rotateTick";
      expectAt(edgeN + 2, P1ROT); kA = 8'h1A;
      step(1'b0); step(1'b1);
      for (int t = 0; t < 20; t++) begin step(1'b0); step(1'b1); end
      kA = 8'h00; idle(3, 1'b0);

      curTag = "pressTick";
      expectAt(edgeN + 2, P1L); kA = 8'h04;
      step(1'b0); step(1'b1);
      for (int t = 1; t <= 16; t++) begin
         step(1'b0);
         if (t == 16) expectAt(edgeN + 1, P1L);
         step(1'b1);
      end
      kA = 8'h00; idle(3, 1'b0);

      curTag = "slotMove";
      expectAt(edgeN + 2, P1L); kA = 8'h04; step(1'b0);
      kA = 8'h00; kB = 8'h04; idle(3, 1'b0);
      kA = 8'h04; idle(2, 1'b0);
      kA = 8'h00; kB = 8'h00; idle(2, 1'b0);
      curTag = "bothSlots";
      expectAt(edgeN + 2, P1R); kA = 8'h07; kB = 8'h07; idle(3, 1'b0);
      kA = 8'h00; kB = 8'h00; idle(2, 1'b0);

      curTag = "downRepeat";
      expectAt(edgeN + 2, P2DN); kA = 8'h51;
      step(1'b0);
      for (int t = 1; t <= 6; t++) begin
         step(1'b0);
         if (t % 2 == 0) expectAt(edgeN + 1, P2DN);
         step(1'b1);
      end
      step(1'b0); step(1'b1);
      curTag = "gateClear";
      gsV = 3'b011;
      for (int t = 0; t < 4; t++) begin step(1'b1); step(1'b0); end
      curTag = "reenterHeld";
      gsV = 3'b010;
      for (int t = 0; t < 6; t++) begin step(1'b0); step(1'b1); end
      kA = 8'h00; idle(2, 1'b0);
      curTag = "downRepress";
      expectAt(edgeN + 2, P2DN); kA = 8'h51; idle(2, 1'b0);
      step(1'b1);

      curTag = "resetMid";
      rstV = 1'b1; step(1'b1);
      rstV = 1'b0;
      for (int t = 0; t < 4; t++) begin step(1'b1); step(1'b0); end
      kA = 8'h00; idle(2, 1'b0);

      nCompared++;
      if (expQ.size() != 0) begin
         nMismatched++;
         $display("FAIL leftover: got %0d pending expectations, required 0", expQ.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
